// File: rtl/timer_unit.sv
// Memory-mapped 64-bit machine timer with prescaler, compare register and level interrupt.
// Word-addressed 32-byte register window; reads are combinational, writes land at the clock edge.
module timer_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned PRE_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        t_intr
);

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic             en_q, en_d;
  logic             ie_q, ie_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic             t_intr_q, t_intr_d;

  logic [2:0] off;
  logic       we, tick;
  logic       wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl, wr_pre;

  // Byte lane bits are don't-care: only word accesses exist.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign hit  = (addr[31:5] == BASE_ADDR[31:5]);
  assign off  = addr[4:2];
  assign we   = hit & wr_en;
  assign tick = en_q & (pcnt_q == pre_q);

  assign wr_mlo  = we & (off == 3'd0);
  assign wr_mhi  = we & (off == 3'd1);
  assign wr_clo  = we & (off == 3'd2);
  assign wr_chi  = we & (off == 3'd3);
  assign wr_ctrl = we & (off == 3'd4);
  assign wr_pre  = we & (off == 3'd5);

  always_comb begin
    mtime_d = mtime_q;
    // Software writes to either half beat the increment for that cycle.
    if (wr_mlo) begin
      mtime_d[31:0] = wdata;
    end else if (wr_mhi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    cmp_d = cmp_q;
    if (wr_clo) cmp_d[31:0]  = wdata;
    if (wr_chi) cmp_d[63:32] = wdata;

    en_d = en_q;
    ie_d = ie_q;
    if (wr_ctrl) begin
      en_d = wdata[0];
      ie_d = wdata[1];
    end

    pre_d = pre_q;
    if (wr_pre) pre_d = wdata[PRE_W-1:0];

    pcnt_d = pcnt_q;
    if (wr_ctrl || wr_pre) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRE_W'(1);
    end

    t_intr_d = ie_q & (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      cmp_q    <= '1;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      t_intr_q <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      t_intr_q <= t_intr_d;
    end
  end

  assign t_intr = t_intr_q;

  always_comb begin
    rdata = '0;
    if (hit && rd_en) begin
      case (off)
        3'd0:    rdata = mtime_q[31:0];
        3'd1:    rdata = mtime_q[63:32];
        3'd2:    rdata = cmp_q[31:0];
        3'd3:    rdata = cmp_q[63:32];
        3'd4:    rdata = {30'd0, ie_q, en_q};
        3'd5:    rdata = {{(32-PRE_W){1'b0}}, pre_q};
        3'd6:    rdata = {31'd0, (mtime_q >= cmp_q)};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: expectations queued at drive time, popped and asserted on sample.
module tb_timer_unit;

  localparam logic [31:0] Base = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic        hit, t_intr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  timer_unit #(
    .BASE_ADDR(Base),
    .PRE_W    (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .t_intr(t_intr)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stimulus changes in the low phase; each write consumes exactly one rising edge.
  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    addr  = Base + {27'd0, off};
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    addr  = Base + {27'd0, off};
    rd_en = 1'b1;
    #1;
    check(tag, rdata);
    rd_en = 1'b0;
  endtask

  task automatic chk_intr(input logic exp, input string tag);
    exp_q.push_back({31'd0, exp});
    #1;
    check(tag, {31'd0, t_intr});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    rd(5'h00, 32'h0, "rst_mtime_lo");
    rd(5'h04, 32'h0, "rst_mtime_hi");
    rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(5'h10, 32'h0, "rst_ctrl");
    rd(5'h14, 32'h0, "rst_prescale");
    rd(5'h18, 32'h0, "rst_status");
    idle(1);
    chk_intr(1'b0, "rst_intr_first_cycle");

    // Basic count
    wr(5'h10, 32'h1);
    idle(10);
    rd(5'h00, 32'd10, "count_lo");
    rd(5'h04, 32'd0, "count_hi");
    chk_intr(1'b0, "count_intr");

    // Prescale of 3: one tick per 4 cycles
    do_reset();
    rd(5'h00, 32'd0, "reset_clears_mtime");
    wr(5'h14, 32'd3);
    wr(5'h10, 32'h1);
    idle(4);
    rd(5'h00, 32'd1, "pre_first_tick");
    idle(16);
    rd(5'h00, 32'd5, "pre_after_20");
    idle(2);
    rd(5'h00, 32'd5, "pre_hold_between_ticks");

    // Carry from LO into HI
    do_reset();
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'h1);
    idle(1);
    rd(5'h00, 32'h0, "carry_lo");
    rd(5'h04, 32'h1, "carry_hi");

    // Full 64-bit wrap
    wr(5'h10, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h10, 32'h1);
    idle(1);
    rd(5'h00, 32'h0, "wrap_lo");
    rd(5'h04, 32'h0, "wrap_hi");

    // Writes in tick cycles win over the increment
    wr(5'h04, 32'h7);
    wr(5'h00, 32'h50);
    rd(5'h00, 32'h50, "collide_lo");
    rd(5'h04, 32'h7, "collide_hi");

    // Interrupt at cmp = 20
    do_reset();
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'd0);
    wr(5'h10, 32'h3);
    rd(5'h13, 32'h3, "ctrl_ignores_byte_bits");
    idle(19);
    rd(5'h18, 32'h0, "status_below_cmp");
    chk_intr(1'b0, "intr_below_cmp");
    idle(1);
    rd(5'h18, 32'h1, "status_at_cmp");
    chk_intr(1'b0, "intr_latency");
    idle(1);
    chk_intr(1'b1, "intr_rises");
    wr(5'h08, 32'd100);
    chk_intr(1'b1, "intr_still_high_at_write");
    idle(1);
    chk_intr(1'b0, "intr_falls");

    // Reset beats a live interrupt and a simultaneous write
    wr(5'h08, 32'd0);
    idle(1);
    chk_intr(1'b1, "intr_high_before_rst");
    rst   = 1'b1;
    addr  = Base;
    wdata = 32'h1234;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk_intr(1'b0, "rst_drops_intr");
    rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_ones");
    rd(5'h00, 32'h0, "rst_beats_write");
    rst = 1'b0;

    // Unmapped and reserved
    addr  = 32'h0000_3000;
    rd_en = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    check("unmapped_rdata", rdata);
    check("unmapped_hit", {31'd0, hit});
    rd_en = 1'b0;
    rd(5'h1C, 32'h0, "reserved_reads_zero");
    exp_q.push_back(32'h1);
    #1;
    check("window_hit", {31'd0, hit});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
